// File: rtl/mac_pkg.sv
// Shared definitions for the MAC divider slice: default widths, FSM states
// and saturation constants at the default quotient width.
package mac_pkg;

    localparam int DEF_FEAT_BIT   = 16;
    localparam int DEF_WEIGHT_BIT = 8;
    localparam int DEF_OUT_BIT    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [DEF_FEAT_BIT-1:0] SAT_POS = {1'b0, {(DEF_FEAT_BIT-1){1'b1}}};
    localparam logic [DEF_FEAT_BIT-1:0] SAT_NEG = {1'b1, {(DEF_FEAT_BIT-1){1'b0}}};

endpackage

// File: rtl/mac_sign_mag.sv
// Conditional two's-complement negate: abs() when neg is the value's own
// sign bit, sign application when neg is the desired result sign.
module mac_sign_mag #(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + 1'b1) : value;

endmodule

// File: rtl/mac_seq_divider.sv
// Sequential signed restoring divider, one quotient bit per cycle.
// Quotient truncates toward zero and saturates; remainder follows the dividend.
module mac_seq_divider
    import mac_pkg::*;
#(
    parameter int FEAT_BIT   = DEF_FEAT_BIT,
    parameter int WEIGHT_BIT = DEF_WEIGHT_BIT,
    parameter int OUT_BIT    = DEF_OUT_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OUT_BIT-1:0]    dividend,
    input  logic [WEIGHT_BIT-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FEAT_BIT-1:0]   quotient,
    output logic [WEIGHT_BIT-1:0] remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int                  CNT_W     = $clog2(OUT_BIT);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(OUT_BIT - 1);
    localparam logic [OUT_BIT-1:0]  Q_POS_LIM = OUT_BIT'((64'd1 << (FEAT_BIT - 1)) - 64'd1);
    localparam logic [OUT_BIT-1:0]  Q_NEG_LIM = OUT_BIT'(64'd1 << (FEAT_BIT - 1));
    localparam logic [FEAT_BIT-1:0] Q_SAT_POS = {1'b0, {(FEAT_BIT-1){1'b1}}};
    localparam logic [FEAT_BIT-1:0] Q_SAT_NEG = {1'b1, {(FEAT_BIT-1){1'b0}}};

    state_t state, state_next;

    // dd_mag shifts dividend magnitude out of the top and quotient bits in at the bottom
    logic [OUT_BIT-1:0]    dd_mag;
    logic [WEIGHT_BIT:0]   rem;
    logic [WEIGHT_BIT-1:0] dv_mag;
    logic [CNT_W-1:0]      count;
    logic                  sign_dd;
    logic                  sign_dv;

    logic [OUT_BIT-1:0]    dd_abs;
    logic [WEIGHT_BIT-1:0] dv_abs;
    logic [WEIGHT_BIT+1:0] rem_wide;
    logic [WEIGHT_BIT:0]   rem_diff;
    logic [WEIGHT_BIT:0]   rem_step;
    logic                  q_bit;
    logic                  q_neg;
    logic                  q_ovf;
    logic [FEAT_BIT-1:0]   q_signed;
    logic [WEIGHT_BIT-1:0] r_signed;

    mac_sign_mag #(.W(OUT_BIT)) u_dd_abs (
        .value  (dividend),
        .neg    (dividend[OUT_BIT-1]),
        .result (dd_abs)
    );

    mac_sign_mag #(.W(WEIGHT_BIT)) u_dv_abs (
        .value  (divisor),
        .neg    (divisor[WEIGHT_BIT-1]),
        .result (dv_abs)
    );

    // Only the low FEAT_BIT bits are negated: whenever the result is not
    // saturated, |q| <= 2^(FEAT_BIT-1) and the truncated negate is exact.
    mac_sign_mag #(.W(FEAT_BIT)) u_q_fix (
        .value  (dd_mag[FEAT_BIT-1:0]),
        .neg    (q_neg),
        .result (q_signed)
    );

    mac_sign_mag #(.W(WEIGHT_BIT)) u_r_fix (
        .value  (rem[WEIGHT_BIT-1:0]),
        .neg    (sign_dd),
        .result (r_signed)
    );

    // One restoring step plus the overflow test on the finished magnitude
    always_comb begin
        rem_wide = {rem, dd_mag[OUT_BIT-1]};
        rem_diff = rem_wide[WEIGHT_BIT:0] - {1'b0, dv_mag};
        q_bit    = (rem_wide >= {2'b00, dv_mag});
        rem_step = q_bit ? rem_diff : rem_wide[WEIGHT_BIT:0];
        q_neg    = sign_dd ^ sign_dv;
        q_ovf    = q_neg ? (dd_mag > Q_NEG_LIM) : (dd_mag > Q_POS_LIM);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and input handshake
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
            end
            CALC:    if (count == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            dd_mag      <= '0;
            rem         <= '0;
            dv_mag      <= '0;
            count       <= '0;
            sign_dd     <= 1'b0;
            sign_dv     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dd_mag  <= dd_abs;
                        dv_mag  <= dv_abs;
                        rem     <= '0;
                        count   <= CNT_LAST;
                        sign_dd <= dividend[OUT_BIT-1];
                        sign_dv <= divisor[WEIGHT_BIT-1];
                        if (divisor == '0) begin
                            quotient    <= '0;
                            remainder   <= dividend[WEIGHT_BIT-1:0];
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    dd_mag <= {dd_mag[OUT_BIT-2:0], q_bit};
                    rem    <= rem_step;
                    count  <= count - 1'b1;
                end
                FIX: begin
                    quotient    <= q_ovf ? (q_neg ? Q_SAT_NEG : Q_SAT_POS) : q_signed;
                    remainder   <= r_signed;
                    div_by_zero <= 1'b0;
                    overflow    <= q_ovf;
                end
                DONE: begin
                    // out_valid is raised one cycle after entering DONE
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid   <= 1'b0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
